// File: rtl/md5_bf_pkg.sv
// md5_bf_pkg: shared state encoding and widths for the MD5 brute-force scheduler
package md5_bf_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int DEF_PIPE_LAT = 65;
   localparam int DIGEST_W = 128;
endpackage

// File: rtl/md5_bf_scheduler_if.sv
// md5_bf_scheduler_if: host/config and MD5-chain signals of the scheduler
interface md5_bf_scheduler_if #(parameter int CW = 32);
   import md5_bf_pkg::*;
   logic                start;
   logic                abort;
   logic                hold;
   logic [CW-1:0]       cand_first;
   logic [CW-1:0]       cand_last;
   logic [DIGEST_W-1:0] target;
   logic [DIGEST_W-1:0] hash_in;
   logic                cand_valid;
   logic [CW-1:0]       cand_idx;
   logic                busy;
   logic                done;
   logic                aborted;
   logic                found;
   logic [CW-1:0]       found_idx;
   modport master (
      output start, abort, hold, cand_first, cand_last, target, hash_in,
      input  cand_valid, cand_idx, busy, done, aborted, found, found_idx
   );
   modport slave (
      input  start, abort, hold, cand_first, cand_last, target, hash_in,
      output cand_valid, cand_idx, busy, done, aborted, found, found_idx
   );
endinterface

// File: rtl/md5_bf_vdelay.sv
// md5_bf_vdelay: 1-bit shift register marking which pipeline slots carry real candidates
module md5_bf_vdelay #(
   parameter int DEPTH = 65
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [DEPTH-1:0] sr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr <= '0;
      else sr <= (sr << 1) | DEPTH'(d);
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/md5_bf_scheduler.sv
// md5_bf_scheduler: issues candidate indices into a fixed-latency MD5 chain, retires
// digests in issue order and records the first index whose digest matches the target.
module md5_bf_scheduler import md5_bf_pkg::*; #(
   parameter int CW = 32,
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int STOP_ON_MATCH = 1
) (
   input logic clk,
   input logic rst_n,
   md5_bf_scheduler_if.slave bus
);
   localparam int IW = $clog2(PIPE_LAT + 2);
   state_t              state;
   logic [CW-1:0]       issue_ctr;
   logic [CW-1:0]       ret_ctr;
   logic [CW-1:0]       last_q;
   logic [DIGEST_W-1:0] target_q;
   logic [IW-1:0]       inflight;
   logic                retire;
   logic                hit;
   logic                stop_hit;
   logic                issue;
   md5_bf_vdelay #(.DEPTH(PIPE_LAT)) u_vdelay (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (bus.cand_valid),
      .q    (retire)
   );
   assign hit      = retire && (bus.hash_in == target_q);
   assign stop_hit = (STOP_ON_MATCH != 0) && hit;
   // a stopping match suppresses the issue in its own cycle so nothing past idx+PIPE_LAT goes out
   assign issue    = (state == RUN) && !bus.hold && !bus.abort && !stop_hit;
   assign bus.busy = state != IDLE;
   // inflight counts issue decisions, so it already covers the slot whose cand_valid is still registered
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         issue_ctr      <= '0;
         ret_ctr        <= '0;
         last_q         <= '0;
         target_q       <= '0;
         inflight       <= '0;
         bus.cand_valid <= 1'b0;
         bus.cand_idx   <= '0;
         bus.done       <= 1'b0;
         bus.aborted    <= 1'b0;
         bus.found      <= 1'b0;
         bus.found_idx  <= '0;
      end else begin
         bus.cand_valid <= issue;
         bus.done       <= 1'b0;
         inflight       <= inflight + IW'(issue) - IW'(retire);
         if (issue) begin
            bus.cand_idx <= issue_ctr;
            issue_ctr    <= issue_ctr + CW'(1);
         end
         if (retire) ret_ctr <= ret_ctr + CW'(1);
         if (hit && !bus.found) begin
            bus.found     <= 1'b1;
            bus.found_idx <= ret_ctr;
         end
         if (bus.abort && (state == RUN || state == DRAIN)) bus.aborted <= 1'b1;
         case (state)
            IDLE:
               if (bus.start) begin
                  issue_ctr     <= bus.cand_first;
                  ret_ctr       <= bus.cand_first;
                  last_q        <= bus.cand_last;
                  target_q      <= bus.target;
                  bus.found     <= 1'b0;
                  bus.found_idx <= '0;
                  bus.aborted   <= 1'b0;
                  state         <= (bus.cand_first <= bus.cand_last) ? RUN : DRAIN;
               end
            RUN:
               if (bus.abort || (issue && issue_ctr == last_q) || stop_hit) state <= DRAIN;
            DRAIN:
               if (inflight == '0 && !retire) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_md5_bf_scheduler.sv
// tb_md5_bf_scheduler: directed checks of issue, retire, match, abort and reset behaviour
// against a digest pipeline model delayed by PIPE_LAT.
module tb_md5_bf_scheduler;
   localparam int L = 65;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   last_cyc = 0;
   int   first_cyc = 0;
   int   start_c = 0;
   int   abort_c = 0;
   int   d0 = 0;
   bit   ok;
   logic [31:0] issued[$];
   logic [L-1:0] pv;
   logic [31:0]  pidx [L];
   md5_bf_scheduler_if #(.CW(32)) bus ();
   md5_bf_scheduler #(.CW(32), .PIPE_LAT(L), .STOP_ON_MATCH(1)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // stand-in digest: the scheduler only compares 128-bit values, any injective map of idx serves
   function automatic logic [127:0] dg(input logic [31:0] i);
      return {i * 32'h9E3779B1, ~i, i ^ 32'hA5A5A5A5, i + 32'h12345678};
   endfunction
   always @(posedge clk or negedge rst_n)
      if (!rst_n) pv <= '0;
      else begin
         pv <= {pv[L-2:0], bus.cand_valid};
         pidx[0] <= bus.cand_idx;
         for (int i = 1; i < L; i++) pidx[i] <= pidx[i-1];
      end
   // idle slots present the target itself, so a compare not gated by retire would be caught
   assign bus.hash_in = pv[L-1] ? dg(pidx[L-1]) : bus.target;
   always @(negedge clk) begin
      if (bus.cand_valid) begin
         if (issued.size() == 0) first_cyc = cyc;
         issued.push_back(bus.cand_idx);
         last_cyc = cyc;
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask
   task automatic start_run(input logic [31:0] f, input logic [31:0] l, input logic [127:0] t);
      @(negedge clk);
      #1;
      bus.cand_first = f;
      bus.cand_last  = l;
      bus.target     = t;
      bus.start      = 1'b1;
      issued.delete();
      start_c = cyc;
      @(negedge clk);
      #1;
      bus.start = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int maxc, input bit tog);
      int n;
      int s;
      n = 0;
      s = done_cnt;
      while (done_cnt == s && n < maxc) begin
         @(negedge clk);
         #1;
         if (tog) bus.hold = ~bus.hold;
         n++;
      end
      bus.hold = 1'b0;
      chk(tag, done_cnt - s, 1);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.hold = 1'b0;
      bus.cand_first = '0;
      bus.cand_last = '0;
      bus.target = '0;
      tick(3);
      chk("reset_outs", {bus.cand_valid, bus.cand_idx, bus.busy, bus.done, bus.aborted, bus.found, bus.found_idx}, '0);
      rst_n = 1'b1;
      tick(2);
      chk("post_reset_idle", {bus.cand_valid, bus.busy, bus.done, bus.found}, '0);
      // 1: full sweep 0..9, match at 5
      start_run(0, 9, dg(5));
      wait_done("t1_done", 200, 1'b0);
      chk("t1_count", issued.size(), 10);
      ok = 1'b1;
      foreach (issued[i]) if (issued[i] != 32'(i)) ok = 1'b0;
      chk("t1_order", ok, 1);
      chk("t1_first_lat", first_cyc - start_c, 2);
      chk("t1_done_lat", done_cyc - last_cyc, L + 2);
      chk("t1_found", bus.found, 1);
      chk("t1_found_idx", bus.found_idx, 5);
      chk("t1_aborted", bus.aborted, 0);
      tick(1);
      chk("t1_idle", {bus.busy, bus.done}, 0);
      // 2: stop on match at 3 in 0..999
      start_run(0, 999, dg(3));
      wait_done("t2_done", 400, 1'b0);
      chk("t2_count", issued.size(), L + 4);
      chk("t2_last_idx", issued[issued.size()-1], 3 + L);
      chk("t2_found_idx", {bus.found, bus.found_idx}, {1'b1, 32'd3});
      chk("t2_done_lat", done_cyc - last_cyc, L + 2);
      // 3: hold toggling, 100..107, match at 104
      start_run(100, 107, dg(104));
      wait_done("t3_done", 300, 1'b1);
      chk("t3_count", issued.size(), 8);
      ok = 1'b1;
      foreach (issued[i]) if (issued[i] != 32'(100 + i)) ok = 1'b0;
      chk("t3_order", ok, 1);
      chk("t3_span", last_cyc - first_cyc, 14);
      chk("t3_found_idx", {bus.found, bus.found_idx}, {1'b1, 32'd104});
      // 6a: empty range
      start_run(5, 4, dg(5));
      wait_done("t6_done", 20, 1'b0);
      chk("t6_done_lat", done_cyc - start_c, 2);
      chk("t6_count", issued.size(), 0);
      chk("t6_found_cleared", bus.found, 0);
      // 4: top of the index space, no wrap
      start_run(32'hFFFF_FFFE, 32'hFFFF_FFFF, dg(7));
      wait_done("t4_done", 200, 1'b0);
      chk("t4_count", issued.size(), 2);
      chk("t4_idx0", issued[0], 32'hFFFF_FFFE);
      chk("t4_idx1", issued[1], 32'hFFFF_FFFF);
      chk("t4_found", bus.found, 0);
      // 6b: start while busy is ignored
      start_run(10, 12, dg(0));
      bus.cand_first = 50;
      bus.cand_last = 60;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      wait_done("t6b_done", 200, 1'b0);
      chk("t6b_count", issued.size(), 3);
      chk("t6b_first", issued[0], 10);
      chk("t6b_last", issued[2], 12);
      // 5: abort part-way through 0..999
      start_run(0, 999, dg(500));
      tick(10);
      bus.abort = 1'b1;
      abort_c = cyc;
      tick(1);
      bus.abort = 1'b0;
      wait_done("t5_done", 300, 1'b0);
      chk("t5_last_issue", last_cyc, abort_c);
      chk("t5_count", issued.size(), abort_c - start_c - 1);
      chk("t5_aborted", bus.aborted, 1);
      chk("t5_done_lat", done_cyc - last_cyc, L + 2);
      tick(2);
      d0 = done_cnt;
      bus.abort = 1'b1;
      tick(2);
      bus.abort = 1'b0;
      tick(2);
      chk("idle_abort_ignored", {bus.busy, bus.aborted, 32'(done_cnt - d0)}, {1'b0, 1'b1, 32'd0});
      // 5b: reset while draining after a match
      start_run(0, 999, dg(2));
      tick(L + 8);
      chk("rst_pre_found", {bus.busy, bus.found, bus.found_idx}, {1'b1, 1'b1, 32'd2});
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {bus.cand_valid, bus.cand_idx, bus.busy, bus.done, bus.aborted, bus.found, bus.found_idx}, '0);
      tick(3);
      rst_n = 1'b1;
      issued.delete();
      d0 = done_cnt;
      tick(L + 5);
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_no_issue", issued.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
